// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared types and constants for the MEM stage: register/data widths,
// the memory op encoding carried down the pipeline from exe_mem, the
// MEM-stage FSM state type and small op-classification helpers.
package mem_access_pkg;

    localparam int RADDR_WIDTH  = 5;
    localparam int RDATA_WIDTH  = 32;
    localparam int MEM_OP_WIDTH = 4;

    localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;
    localparam logic [RDATA_WIDTH-1:0] ZERO     = '0;

    typedef enum logic [MEM_OP_WIDTH-1:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic is_load(input logic [MEM_OP_WIDTH-1:0] op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(input logic [MEM_OP_WIDTH-1:0] op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if
// Data bus between the MEM stage (master) and data memory (slave).
//   dbus_req_o    request valid, held until dbus_gnt_i
//   dbus_we_o     1 = store
//   dbus_addr_o   word-aligned address
//   dbus_be_o     byte enables
//   dbus_wdata_o  store data, already shifted to its byte lanes
//   dbus_gnt_i    request accepted this cycle
//   dbus_rvalid_i response (load data or store ack) valid
//   dbus_rdata_i  load data word
interface mem_access_if;
    import mem_access_pkg::*;

    logic                   dbus_req_o;
    logic                   dbus_we_o;
    logic [RDATA_WIDTH-1:0] dbus_addr_o;
    logic [3:0]             dbus_be_o;
    logic [RDATA_WIDTH-1:0] dbus_wdata_o;
    logic                   dbus_gnt_i;
    logic                   dbus_rvalid_i;
    logic [RDATA_WIDTH-1:0] dbus_rdata_i;

    modport master (
        output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
        input  dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
    );

    modport slave (
        input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
        output dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
    );

endinterface

// File: rtl/mem_access_lsu_align.sv
// mem_lsu_align
// Purely combinational lane logic for the MEM stage.
//   mem_op    memory op code
//   addr_lo   low two bits of the effective address
//   sdata     raw store data (rs2)
//   rdata     raw load data word
//   be        byte enables (all ones for loads and word stores)
//   wdata     store data replicated onto every candidate lane
//   misalign  halfword/word access not naturally aligned
//   load_data selected byte/half/word, sign- or zero-extended
module mem_lsu_align
    import mem_access_pkg::*;
(
    input  logic [MEM_OP_WIDTH-1:0] mem_op,
    input  logic [1:0]              addr_lo,
    input  logic [RDATA_WIDTH-1:0]  sdata,
    input  logic [RDATA_WIDTH-1:0]  rdata,
    output logic [3:0]              be,
    output logic [RDATA_WIDTH-1:0]  wdata,
    output logic                    misalign,
    output logic [RDATA_WIDTH-1:0]  load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Stores replicate the data across the word so memory only needs the
    // byte enables to pick the lane; the replication is lane-agnostic.
    always_comb begin
        be       = 4'b1111;
        wdata    = sdata;
        misalign = 1'b0;
        case (mem_op)
            MEM_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
            end
            MEM_SH: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{sdata[15:0]}};
                misalign = addr_lo[0];
            end
            MEM_SW:          misalign = |addr_lo;
            MEM_LH, MEM_LHU: misalign = addr_lo[0];
            MEM_LW:          misalign = |addr_lo;
            default: ;
        endcase
    end

    // Loads pick the addressed byte/half out of the returned word.
    always_comb begin
        ld_byte   = rdata[{addr_lo, 3'b000} +: 8];
        ld_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (mem_op)
            MEM_LB:  load_data = {{24{ld_byte[7]}}, ld_byte};
            MEM_LBU: load_data = {24'd0, ld_byte};
            MEM_LH:  load_data = {{16{ld_half[15]}}, ld_half};
            MEM_LHU: load_data = {16'd0, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access
// MEM stage of the 5-stage core. Non-memory ops pass straight through to
// mem_wb; loads/stores run a req/gnt/rvalid handshake and hold the rest of
// the pipeline with stall_req_o until the result is ready.
//   clk_i, rst_i          clock, synchronous active-high reset
//   reg_*_i, mem_op_i,
//   mem_sdata_i           exe_mem register outputs
//   dbus                  data bus (master side)
//   reg_*_o               writeback triple to mem_wb
//   stall_req_o           freeze request to pipeline control
//   misalign_o            pulse: misaligned access dropped
//   bus_err_o             pulse: response timeout
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
)(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [RADDR_WIDTH-1:0]  reg_waddr_i,
    input  logic                    reg_we_i,
    input  logic [RDATA_WIDTH-1:0]  reg_wdata_i,
    input  logic [MEM_OP_WIDTH-1:0] mem_op_i,
    input  logic [RDATA_WIDTH-1:0]  mem_sdata_i,
    mem_access_if.master            dbus,
    output logic [RADDR_WIDTH-1:0]  reg_waddr_o,
    output logic                    reg_we_o,
    output logic [RDATA_WIDTH-1:0]  reg_wdata_o,
    output logic                    stall_req_o,
    output logic                    misalign_o,
    output logic                    bus_err_o
);

    localparam logic [7:0] TIMEOUT_VAL = TIMEOUT_CYC[7:0];

    state_e                 state;
    logic [7:0]             cnt;
    logic [7:0]             cnt_inc;
    logic [RDATA_WIDTH-1:0] rdata_q;
    logic                   err_q;

    logic                   op_load;
    logic                   op_store;
    logic                   op_mem;
    logic                   issue;
    logic [3:0]             lsu_be;
    logic [RDATA_WIDTH-1:0] lsu_wdata;
    logic                   lsu_misalign;
    logic [RDATA_WIDTH-1:0] lsu_load_data;

    assign op_load  = is_load(mem_op_i);
    assign op_store = is_store(mem_op_i);
    assign op_mem   = op_load | op_store;
    assign issue    = op_mem & ~lsu_misalign;
    assign cnt_inc  = cnt + 8'd1;

    // Load extraction works on the latched word; exe_mem is frozen during
    // the access so the address bits are still valid in DONE.
    mem_lsu_align u_align (
        .mem_op    (mem_op_i),
        .addr_lo   (reg_wdata_i[1:0]),
        .sdata     (mem_sdata_i),
        .rdata     (rdata_q),
        .be        (lsu_be),
        .wdata     (lsu_wdata),
        .misalign  (lsu_misalign),
        .load_data (lsu_load_data)
    );

    // Handshake FSM. The counter only means something in WAIT and is
    // cleared on every entry, so no separate clear is needed elsewhere.
    // rvalid beats the timeout when both land on the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= ZERO;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        cnt   <= '0;
                        err_q <= 1'b0;
                        state <= dbus.dbus_gnt_i ? WAIT : REQ;
                    end
                end
                REQ: begin
                    if (dbus.dbus_gnt_i) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt_inc;
                    if (dbus.dbus_rvalid_i) begin
                        rdata_q <= dbus.dbus_rdata_i;
                        err_q   <= 1'b0;
                        state   <= DONE;
                    end else if (cnt_inc == TIMEOUT_VAL) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are combinational so a plain op and the first request cycle
    // cost no extra latency. While an access is in flight mem_wb sees a
    // bubble (reg_we_o 0); reset forces every output to its idle value.
    always_comb begin
        dbus.dbus_req_o   = 1'b0;
        dbus.dbus_we_o    = 1'b0;
        dbus.dbus_addr_o  = ZERO;
        dbus.dbus_be_o    = 4'b0000;
        dbus.dbus_wdata_o = ZERO;
        reg_waddr_o       = ZERO_REG;
        reg_we_o          = 1'b0;
        reg_wdata_o       = ZERO;
        stall_req_o       = 1'b0;
        misalign_o        = 1'b0;
        bus_err_o         = 1'b0;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    reg_waddr_o = reg_waddr_i;
                    reg_wdata_o = reg_wdata_i;
                    if (!op_mem) begin
                        reg_we_o = reg_we_i;
                    end else if (lsu_misalign) begin
                        misalign_o = 1'b1;
                    end else begin
                        dbus.dbus_req_o   = 1'b1;
                        dbus.dbus_we_o    = op_store;
                        dbus.dbus_addr_o  = {reg_wdata_i[31:2], 2'b00};
                        dbus.dbus_be_o    = lsu_be;
                        dbus.dbus_wdata_o = op_store ? lsu_wdata : ZERO;
                        stall_req_o       = 1'b1;
                    end
                end
                REQ: begin
                    dbus.dbus_req_o   = 1'b1;
                    dbus.dbus_we_o    = op_store;
                    dbus.dbus_addr_o  = {reg_wdata_i[31:2], 2'b00};
                    dbus.dbus_be_o    = lsu_be;
                    dbus.dbus_wdata_o = op_store ? lsu_wdata : ZERO;
                    stall_req_o       = 1'b1;
                end
                WAIT: stall_req_o = 1'b1;
                DONE: begin
                    reg_waddr_o = reg_waddr_i;
                    reg_wdata_o = reg_wdata_i;
                    if (err_q) begin
                        bus_err_o = 1'b1;
                    end else if (op_load) begin
                        reg_wdata_o = lsu_load_data;
                        reg_we_o    = reg_we_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access
// Directed bench for the MEM stage. Inputs change 1 time unit after each
// rising edge and outputs are looked at 1 unit later, well away from edges.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_sdata_i;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        stall_req_o;
    logic        misalign_o;
    logic        bus_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_if bus();

    mem_access #(.TIMEOUT_CYC(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .reg_waddr_i (reg_waddr_i),
        .reg_we_i    (reg_we_i),
        .reg_wdata_i (reg_wdata_i),
        .mem_op_i    (mem_op_i),
        .mem_sdata_i (mem_sdata_i),
        .dbus        (bus),
        .reg_waddr_o (reg_waddr_o),
        .reg_we_o    (reg_we_o),
        .reg_wdata_o (reg_wdata_o),
        .stall_req_o (stall_req_o),
        .misalign_o  (misalign_o),
        .bus_err_o   (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] waddr, input logic we,
                         input logic [31:0] wdata, input logic [31:0] sdata);
        mem_op_i    = op;
        reg_waddr_i = waddr;
        reg_we_i    = we;
        reg_wdata_i = wdata;
        mem_sdata_i = sdata;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        bus.dbus_gnt_i = 1'b0; bus.dbus_rvalid_i = 1'b0; bus.dbus_rdata_i = 32'h0;
        drive(MEM_NONE, 5'd7, 1'b1, 32'h55, 32'h0);
        tick(); tick(); #1;
        n_checks++;
        if ({reg_waddr_o, reg_we_o, reg_wdata_o} !== {5'd0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL reset_wb: got %0d/%0b/%h expected 0/0/00000000", reg_waddr_o, reg_we_o, reg_wdata_o);
        end
        n_checks++;
        if ({stall_req_o, bus.dbus_req_o, misalign_o, bus_err_o} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got stall/req/mis/err %b expected 0000",
                     {stall_req_o, bus.dbus_req_o, misalign_o, bus_err_o});
        end
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_passthrough();
        tick();
        drive(MEM_NONE, 5'd5, 1'b1, 32'h1234, 32'h0);
        #1;
        n_checks++;
        if ({reg_waddr_o, reg_we_o, reg_wdata_o} !== {5'd5, 1'b1, 32'h1234}) begin
            n_fail++;
            $display("[TB] FAIL pass_wb: got %0d/%0b/%h expected 5/1/00001234", reg_waddr_o, reg_we_o, reg_wdata_o);
        end
        n_checks++;
        if ({stall_req_o, bus.dbus_req_o} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL pass_ctrl: got stall/req %b expected 00", {stall_req_o, bus.dbus_req_o});
        end
    endtask

    task automatic test_load_lb();
        tick();
        drive(MEM_LB, 5'd3, 1'b1, 32'h103, 32'h0);
        bus.dbus_gnt_i = 1'b1;
        #1;
        n_checks++;
        if ({bus.dbus_req_o, bus.dbus_we_o, bus.dbus_addr_o, bus.dbus_be_o} !== {1'b1, 1'b0, 32'h100, 4'b1111}) begin
            n_fail++;
            $display("[TB] FAIL lb_req: got req/we/addr/be %b/%b/%h/%b expected 1/0/00000100/1111",
                     bus.dbus_req_o, bus.dbus_we_o, bus.dbus_addr_o, bus.dbus_be_o);
        end
        n_checks++;
        if ({stall_req_o, reg_we_o} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL lb_stall_c0: got stall/we %b expected 10", {stall_req_o, reg_we_o});
        end
        tick();
        bus.dbus_gnt_i = 1'b0; bus.dbus_rvalid_i = 1'b1; bus.dbus_rdata_i = 32'h80AABBCC;
        #1;
        n_checks++;
        if ({stall_req_o, bus.dbus_req_o} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL lb_wait: got stall/req %b expected 10", {stall_req_o, bus.dbus_req_o});
        end
        tick();
        bus.dbus_rvalid_i = 1'b0; bus.dbus_rdata_i = 32'h0;
        #1;
        n_checks++;
        if ({stall_req_o, reg_waddr_o, reg_we_o, reg_wdata_o} !== {1'b0, 5'd3, 1'b1, 32'hFFFFFF80}) begin
            n_fail++;
            $display("[TB] FAIL lb_done: got stall/waddr/we/wdata %b/%0d/%b/%h expected 0/3/1/ffffff80",
                     stall_req_o, reg_waddr_o, reg_we_o, reg_wdata_o);
        end
    endtask

    task automatic do_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] word,
                           input logic [31:0] expected);
        tick();
        drive(op, 5'd9, 1'b1, addr, 32'h0);
        bus.dbus_gnt_i = 1'b1;
        tick();
        bus.dbus_gnt_i = 1'b0; bus.dbus_rvalid_i = 1'b1; bus.dbus_rdata_i = word;
        tick();
        bus.dbus_rvalid_i = 1'b0; bus.dbus_rdata_i = 32'h0;
        #1;
        n_checks++;
        if ({stall_req_o, reg_we_o, reg_wdata_o} !== {1'b0, 1'b1, expected}) begin
            n_fail++;
            $display("[TB] FAIL load op%0d @%h: got stall/we/wdata %b/%b/%h expected 0/1/%h",
                     op, addr, stall_req_o, reg_we_o, reg_wdata_o, expected);
        end
    endtask

    task automatic test_load_variants();
        do_load(MEM_LH,  32'h10,  32'h80AABBCC, 32'hFFFFBBCC);
        do_load(MEM_LHU, 32'h12,  32'h80AABBCC, 32'h000080AA);
        do_load(MEM_LBU, 32'h11,  32'h80AABBCC, 32'h000000BB);
        do_load(MEM_LB,  32'h12,  32'h80AABBCC, 32'hFFFFFFAA);
        do_load(MEM_LW,  32'h14,  32'h80AABBCC, 32'h80AABBCC);
        do_load(MEM_LB,  32'h100, 32'h0000007F, 32'h0000007F);
    endtask

    task automatic test_store_sh_delayed_gnt();
        tick();
        drive(MEM_SH, 5'd9, 1'b1, 32'h202, 32'h0000BEEF);
        for (int i = 0; i < 5; i++) begin
            bus.dbus_gnt_i = (i == 4);
            #1;
            n_checks++;
            if ({bus.dbus_req_o, bus.dbus_we_o, bus.dbus_addr_o, bus.dbus_be_o, bus.dbus_wdata_o, stall_req_o}
                !== {1'b1, 1'b1, 32'h200, 4'b1100, 32'hBEEFBEEF, 1'b1}) begin
                n_fail++;
                $display("[TB] FAIL sh_req_c%0d: got req/we/addr/be/wdata/stall %b/%b/%h/%b/%h/%b expected 1/1/00000200/1100/beefbeef/1",
                         i, bus.dbus_req_o, bus.dbus_we_o, bus.dbus_addr_o, bus.dbus_be_o, bus.dbus_wdata_o, stall_req_o);
            end
            tick();
        end
        bus.dbus_gnt_i = 1'b0; bus.dbus_rvalid_i = 1'b1;
        #1;
        n_checks++;
        if ({bus.dbus_req_o, stall_req_o} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL sh_wait: got req/stall %b expected 01", {bus.dbus_req_o, stall_req_o});
        end
        tick();
        bus.dbus_rvalid_i = 1'b0;
        #1;
        n_checks++;
        if ({stall_req_o, reg_we_o} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL sh_done: got stall/we %b expected 00", {stall_req_o, reg_we_o});
        end
    endtask

    task automatic do_store(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        tick();
        drive(op, 5'd2, 1'b1, addr, sdata);
        bus.dbus_gnt_i = 1'b1;
        #1;
        n_checks++;
        if ({bus.dbus_req_o, bus.dbus_we_o, bus.dbus_addr_o, bus.dbus_be_o, bus.dbus_wdata_o}
            !== {1'b1, 1'b1, exp_addr, exp_be, exp_wdata}) begin
            n_fail++;
            $display("[TB] FAIL store op%0d @%h: got req/we/addr/be/wdata %b/%b/%h/%b/%h expected 1/1/%h/%b/%h",
                     op, addr, bus.dbus_req_o, bus.dbus_we_o, bus.dbus_addr_o, bus.dbus_be_o, bus.dbus_wdata_o,
                     exp_addr, exp_be, exp_wdata);
        end
        tick();
        bus.dbus_gnt_i = 1'b0; bus.dbus_rvalid_i = 1'b1;
        tick();
        bus.dbus_rvalid_i = 1'b0;
        #1;
        n_checks++;
        if ({stall_req_o, reg_we_o} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL store_done op%0d: got stall/we %b expected 00", op, {stall_req_o, reg_we_o});
        end
    endtask

    task automatic test_stores();
        do_store(MEM_SB, 32'h301, 32'h12345678, 32'h300, 4'b0010, 32'h78787878);
        do_store(MEM_SB, 32'h303, 32'h000000A5, 32'h300, 4'b1000, 32'hA5A5A5A5);
        do_store(MEM_SH, 32'h300, 32'hCAFE1234, 32'h300, 4'b0011, 32'h12341234);
        do_store(MEM_SW, 32'h44,  32'hDEADBEEF, 32'h44,  4'b1111, 32'hDEADBEEF);
    endtask

    task automatic do_misalign(input logic [3:0] op, input logic [31:0] addr);
        tick();
        drive(op, 5'd4, 1'b1, addr, 32'hFFFF_FFFF);
        bus.dbus_gnt_i = 1'b1;
        #1;
        n_checks++;
        if ({misalign_o, bus.dbus_req_o, reg_we_o, stall_req_o} !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL misalign op%0d @%h: got mis/req/we/stall %b expected 1000",
                     op, addr, {misalign_o, bus.dbus_req_o, reg_we_o, stall_req_o});
        end
        tick();
        bus.dbus_gnt_i = 1'b0;
        drive(MEM_NONE, 5'd1, 1'b1, 32'h77, 32'h0);
        #1;
        n_checks++;
        if ({misalign_o, stall_req_o, reg_we_o} !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL misalign_after op%0d: got mis/stall/we %b expected 001",
                     op, {misalign_o, stall_req_o, reg_we_o});
        end
    endtask

    task automatic test_misalign();
        do_misalign(MEM_LW,  32'h006);
        do_misalign(MEM_SH,  32'h201);
        do_misalign(MEM_LHU, 32'h003);
        do_misalign(MEM_SW,  32'h002);
    endtask

    task automatic test_timeout();
        tick();
        drive(MEM_LW, 5'd6, 1'b1, 32'h40, 32'h0);
        bus.dbus_gnt_i = 1'b1;
        tick();
        bus.dbus_gnt_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            n_checks++;
            if ({stall_req_o, bus_err_o, bus.dbus_req_o} !== 3'b100) begin
                n_fail++;
                $display("[TB] FAIL timeout_wait_c%0d: got stall/err/req %b expected 100",
                         i, {stall_req_o, bus_err_o, bus.dbus_req_o});
            end
            tick();
        end
        #1;
        n_checks++;
        if ({bus_err_o, reg_we_o, stall_req_o} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL timeout_done: got err/we/stall %b expected 100", {bus_err_o, reg_we_o, stall_req_o});
        end
        tick();
        drive(MEM_NONE, 5'd8, 1'b1, 32'h99, 32'h0);
        #1;
        n_checks++;
        if ({bus_err_o, stall_req_o, reg_we_o, reg_wdata_o} !== {3'b001, 32'h99}) begin
            n_fail++;
            $display("[TB] FAIL timeout_idle: got err/stall/we/wdata %b/%b/%b/%h expected 0/0/1/00000099",
                     bus_err_o, stall_req_o, reg_we_o, reg_wdata_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        tick();
        drive(MEM_LW, 5'd10, 1'b1, 32'h80, 32'h0);
        bus.dbus_gnt_i = 1'b1;
        tick();
        bus.dbus_gnt_i = 1'b0;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if ({stall_req_o, bus.dbus_req_o, reg_we_o} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL rst_wait_hold: got stall/req/we %b expected 000", {stall_req_o, bus.dbus_req_o, reg_we_o});
        end
        tick();
        rst_i = 1'b0;
        drive(MEM_NONE, 5'd0, 1'b0, 32'h0, 32'h0);
        bus.dbus_rvalid_i = 1'b1; bus.dbus_rdata_i = 32'h12345678;
        #1;
        n_checks++;
        if ({stall_req_o, bus.dbus_req_o, bus_err_o, reg_waddr_o, reg_we_o, reg_wdata_o}
            !== {3'b000, 5'd0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL rst_late_rvalid: got stall/req/err/waddr/we/wdata %b/%b/%b/%0d/%b/%h expected 0/0/0/0/0/00000000",
                     stall_req_o, bus.dbus_req_o, bus_err_o, reg_waddr_o, reg_we_o, reg_wdata_o);
        end
        tick();
        bus.dbus_rvalid_i = 1'b0; bus.dbus_rdata_i = 32'h0;
        drive(MEM_NONE, 5'd6, 1'b1, 32'hABCD, 32'h0);
        #1;
        n_checks++;
        if ({stall_req_o, reg_waddr_o, reg_we_o, reg_wdata_o} !== {1'b0, 5'd6, 1'b1, 32'hABCD}) begin
            n_fail++;
            $display("[TB] FAIL rst_then_pass: got stall/waddr/we/wdata %b/%0d/%b/%h expected 0/6/1/0000abcd",
                     stall_req_o, reg_waddr_o, reg_we_o, reg_wdata_o);
        end
    endtask

    // Drive the scenarios in order, then report.
    initial begin
        test_reset();
        test_passthrough();
        test_load_lb();
        test_load_variants();
        test_store_sh_delayed_gnt();
        test_stores();
        test_misalign();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
